// File: rtl/andrewm_uart_to_parallel.sv
// UART 8N1 receiver: serial line in, one-entry byte holding register out with a
// valid/ready handshake, nibble read-out mux and sticky framing/overrun flags.
module andrewm_uart_to_parallel #(
    parameter int CLKS_PER_BIT = 256,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       out_ready,
    input  logic       err_clear,
    input  logic       nibble_sel,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [3:0] nibble_out,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign nibble_out = nibble_sel ? out_data[7:4] : out_data[3:0];

    // Synchronizer, receive FSM, holding register and sticky flags.
    // Later assignments in the same cycle override earlier ones, so a delivery
    // or flag-set event wins over the handshake drain and err_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (err_clear) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Back to IDLE mid stop bit so the next start edge is caught.
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!out_valid || out_ready) begin
                                out_data  <= shift;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
